// File: rtl/energy_agg_pkg.sv
// Shared types and constants for the energy sample aggregator: output field
// select codes, the queued frame record, min/max reset values and FIFO states.
package energy_agg_pkg;

    typedef enum logic [1:0] {
        SEL_AVG = 2'd0,
        SEL_MIN = 2'd1,
        SEL_MAX = 2'd2,
        SEL_CNT = 2'd3
    } sel_e;

    // Frame fields are sized for the largest supported configuration; the top
    // zero-extends into them and slices back out.
    localparam int unsigned AGG_MAX_CH_W   = 3;
    localparam int unsigned AGG_MAX_DATA_W = 16;

    typedef struct packed {
        logic [AGG_MAX_CH_W-1:0]   ch;
        logic [AGG_MAX_DATA_W-1:0] data;
    } frame_t;

    localparam logic [AGG_MAX_DATA_W-1:0] MIN_RESET = '1;
    localparam logic [AGG_MAX_DATA_W-1:0] MAX_RESET = '0;

    typedef enum logic [1:0] {
        FIFO_EMPTY = 2'd0,
        FIFO_ONE   = 2'd1,
        FIFO_TWO   = 2'd2
    } fifo_state_e;

endpackage

// File: rtl/agg_frame_fifo.sv
// Two-entry frame queue with registered head slot; reports empty/full and
// flags a push that arrives while full with no same-cycle pop.
module agg_frame_fifo
    import energy_agg_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   flush,
    input  logic   push,
    input  frame_t push_frame,
    input  logic   pop,
    output frame_t head,
    output logic   empty,
    output logic   full,
    output logic   drop
);

    fifo_state_e state_q, state_d;
    frame_t      slot0_q, slot0_d;
    frame_t      slot1_q, slot1_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FIFO_EMPTY;
            slot0_q <= '0;
            slot1_q <= '0;
        end else begin
            state_q <= state_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        drop    = 1'b0;
        if (flush) begin
            state_d = FIFO_EMPTY;
            slot0_d = '0;
            slot1_d = '0;
        end else begin
            case (state_q)
                FIFO_EMPTY: begin
                    if (push) begin
                        slot0_d = push_frame;
                        state_d = FIFO_ONE;
                    end
                end
                FIFO_ONE: begin
                    if (push && pop) begin
                        slot0_d = push_frame;
                    end else if (push) begin
                        slot1_d = push_frame;
                        state_d = FIFO_TWO;
                    end else if (pop) begin
                        state_d = FIFO_EMPTY;
                    end
                end
                FIFO_TWO: begin
                    // Pop is taken before push, so a full queue still accepts
                    // a frame on a cycle where the head leaves.
                    if (pop) begin
                        slot0_d = slot1_q;
                        if (push) begin
                            slot1_d = push_frame;
                        end else begin
                            state_d = FIFO_ONE;
                        end
                    end else if (push) begin
                        drop = 1'b1;
                    end
                end
                default: state_d = FIFO_EMPTY;
            endcase
        end
    end

    assign head  = slot0_q;
    assign empty = (state_q == FIFO_EMPTY);
    assign full  = (state_q == FIFO_TWO);

endmodule

// File: rtl/energy_sample_aggregator.sv
// Per-channel boxcar average plus min/max over 2^LOG2_AVG samples, streamed out
// through a 2-frame queue. VEDM_AGG_THRESH_EN adds the thresh input / alarm output.
module energy_sample_aggregator
    import energy_agg_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned N_CH     = 4,
    parameter int unsigned LOG2_AVG = 3,
    parameter int unsigned CH_W     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              in_valid,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [DATA_W-1:0] in_data,
    input  logic              clr,
    input  logic [1:0]        sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_ch,
    output logic [DATA_W-1:0] out_data,
`ifdef VEDM_AGG_THRESH_EN
    input  logic [DATA_W-1:0] thresh,
    output logic [N_CH-1:0]   alarm,
`endif
    output logic              overrun
);

    localparam int unsigned       SUM_W     = DATA_W + LOG2_AVG;
    localparam int unsigned       IDX_W     = $clog2(N_CH);
    localparam logic [DATA_W-1:0] CNT_FIELD = DATA_W'(1 << LOG2_AVG);
    localparam logic [DATA_W-1:0] MIN_INIT  = MIN_RESET[DATA_W-1:0];
    localparam logic [DATA_W-1:0] MAX_INIT  = MAX_RESET[DATA_W-1:0];

    logic [SUM_W-1:0]    sum_q [N_CH];
    logic [LOG2_AVG-1:0] cnt_q [N_CH];
    logic [DATA_W-1:0]   min_q [N_CH];
    logic [DATA_W-1:0]   max_q [N_CH];

    logic              clr_en;
    logic              in_range;
    logic              accept;
    logic              win_done;
    logic [IDX_W-1:0]  idx;
    logic [SUM_W-1:0]  sum_next;
    logic [DATA_W-1:0] avg;
    logic [DATA_W-1:0] min_next;
    logic [DATA_W-1:0] max_next;
    logic [DATA_W-1:0] field;
    frame_t            push_frame;
    frame_t            head_frame;
    logic              fifo_empty;
    logic              fifo_full;
    logic              fifo_drop;
    logic              pop;

    if ((1 << CH_W) > N_CH) begin : g_range_chk
        assign in_range = (in_ch < CH_W'(N_CH));
    end else begin : g_range_all
        assign in_range = 1'b1;
    end

    assign idx      = in_ch[IDX_W-1:0];
    assign clr_en   = ena && clr;
    assign accept   = ena && in_valid && in_range && !clr;
    assign win_done = accept && (cnt_q[idx] == '1);

    // The frame includes the sample being accepted this cycle.
    always_comb begin
        sum_next = sum_q[idx] + SUM_W'(in_data);
        avg      = sum_next[SUM_W-1:LOG2_AVG];
        min_next = (in_data < min_q[idx]) ? in_data : min_q[idx];
        max_next = (in_data > max_q[idx]) ? in_data : max_q[idx];
    end

    always_comb begin
        field = avg;
        case (sel_e'(sel))
            SEL_MIN: field = min_next;
            SEL_MAX: field = max_next;
            SEL_CNT: field = CNT_FIELD;
            default: field = avg;
        endcase
    end

    always_comb begin
        push_frame      = '0;
        push_frame.ch   = AGG_MAX_CH_W'(in_ch);
        push_frame.data = AGG_MAX_DATA_W'(field);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '{default: '0};
            cnt_q <= '{default: '0};
            min_q <= '{default: MIN_INIT};
            max_q <= '{default: MAX_INIT};
        end else if (clr_en) begin
            sum_q <= '{default: '0};
            cnt_q <= '{default: '0};
            min_q <= '{default: MIN_INIT};
            max_q <= '{default: MAX_INIT};
        end else if (accept) begin
            if (win_done) begin
                sum_q[idx] <= '0;
                cnt_q[idx] <= '0;
                min_q[idx] <= MIN_INIT;
                max_q[idx] <= MAX_INIT;
            end else begin
                sum_q[idx] <= sum_next;
                cnt_q[idx] <= cnt_q[idx] + LOG2_AVG'(1);
                min_q[idx] <= min_next;
                max_q[idx] <= max_next;
            end
        end
    end

    assign pop = !fifo_empty && out_ready && ena;

    agg_frame_fifo u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (clr_en),
        .push       (win_done),
        .push_frame (push_frame),
        .pop        (pop),
        .head       (head_frame),
        .empty      (fifo_empty),
        .full       (fifo_full),
        .drop       (fifo_drop)
    );

    a_drop_only_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_drop |-> fifo_full);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (clr_en) begin
            overrun <= 1'b0;
        end else if (fifo_drop) begin
            overrun <= 1'b1;
        end
    end

    assign out_valid = !fifo_empty;
    assign out_ch    = head_frame.ch[CH_W-1:0];
    assign out_data  = head_frame.data[DATA_W-1:0];

    if (AGG_MAX_CH_W > CH_W) begin : g_ch_pad
        logic unused_ch_pad;
        assign unused_ch_pad = ^head_frame.ch[AGG_MAX_CH_W-1:CH_W];
    end
    if (AGG_MAX_DATA_W > DATA_W) begin : g_data_pad
        logic unused_data_pad;
        assign unused_data_pad = ^head_frame.data[AGG_MAX_DATA_W-1:DATA_W];
    end

`ifdef VEDM_AGG_THRESH_EN
    logic [N_CH-1:0] alarm_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_q <= '0;
        end else if (clr_en) begin
            alarm_q <= '0;
        end else if (win_done) begin
            alarm_q[idx] <= (avg < thresh);
        end
    end

    assign alarm = alarm_q;
`endif

endmodule

// File: tb/tb_energy_sample_aggregator.sv
// Self-checking bench for energy_sample_aggregator: window table plus
// hand-written overrun, clear, enable, out-of-range and reset sequences.
module tb_energy_sample_aggregator;

    localparam int DATA_W   = 8;
    localparam int N_CH     = 4;
    localparam int LOG2_AVG = 3;
    localparam int CH_W     = 3;
    localparam int WIN      = 1 << LOG2_AVG;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ena;
    logic              in_valid;
    logic [CH_W-1:0]   in_ch;
    logic [DATA_W-1:0] in_data;
    logic              clr;
    logic [1:0]        sel;
    logic              out_valid;
    logic              out_ready;
    logic [CH_W-1:0]   out_ch;
    logic [DATA_W-1:0] out_data;
    logic              overrun;
`ifdef VEDM_AGG_THRESH_EN
    logic [DATA_W-1:0] thresh;
    logic [N_CH-1:0]   alarm;
`endif

    always #5 clk = ~clk;

    energy_sample_aggregator #(
        .DATA_W   (DATA_W),
        .N_CH     (N_CH),
        .LOG2_AVG (LOG2_AVG),
        .CH_W     (CH_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .in_valid  (in_valid),
        .in_ch     (in_ch),
        .in_data   (in_data),
        .clr       (clr),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_data  (out_data),
`ifdef VEDM_AGG_THRESH_EN
        .thresh    (thresh),
        .alarm     (alarm),
`endif
        .overrun   (overrun)
    );

    typedef struct { int ch; int data; } exp_t;
    typedef struct { int ch; int d0; int step; int sel; int exp; } vec_t;

    exp_t exp_q[$];
    int   m_sum [N_CH];
    int   m_cnt [N_CH];
    int   m_min [N_CH];
    int   m_max [N_CH];
    bit   exp_ovr;
    int   total;
    int   bad;
    int   pops_seen;
    int   last_pop_data;
    vec_t vec [8];

    task automatic check(input string name, input logic [31:0] act, input int exp);
        total++;
        if (act !== 32'(exp)) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset_chans();
        for (int i = 0; i < N_CH; i++) begin
            m_sum[i] = 0;
            m_cnt[i] = 0;
            m_min[i] = 255;
            m_max[i] = 0;
        end
    endfunction

    // One clock: drive, check outputs against the scoreboard head, then
    // advance the model to what the coming edge must do.
    task automatic step(input logic v, input int ch, input int d);
        exp_t f;
        int   d8;
        d8       = d & 255;
        in_valid = v;
        in_ch    = ch[CH_W-1:0];
        in_data  = d8[DATA_W-1:0];
        @(negedge clk);
        check("out_valid", out_valid, int'(exp_q.size() > 0));
        check("overrun", overrun, int'(exp_ovr));
        if (exp_q.size() > 0) begin
            check("out_ch", out_ch, exp_q[0].ch);
            check("out_data", out_data, exp_q[0].data);
        end
        if (out_valid && out_ready && ena) begin
            pops_seen++;
            last_pop_data = int'(out_data);
        end
        if (ena && clr) begin
            exp_q.delete();
            exp_ovr = 1'b0;
            model_reset_chans();
        end else begin
            if (exp_q.size() > 0 && out_ready && ena) void'(exp_q.pop_front());
            if (ena && v && ch < N_CH) begin
                m_sum[ch] += d8;
                m_cnt[ch]++;
                if (d8 < m_min[ch]) m_min[ch] = d8;
                if (d8 > m_max[ch]) m_max[ch] = d8;
                if (m_cnt[ch] == WIN) begin
                    f.ch = ch;
                    case (sel)
                        2'd0:    f.data = m_sum[ch] >> LOG2_AVG;
                        2'd1:    f.data = m_min[ch];
                        2'd2:    f.data = m_max[ch];
                        default: f.data = WIN;
                    endcase
                    if (exp_q.size() < 2) exp_q.push_back(f);
                    else exp_ovr = 1'b1;
                    m_sum[ch] = 0;
                    m_cnt[ch] = 0;
                    m_min[ch] = 255;
                    m_max[ch] = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic window(input int ch, input int d);
        for (int i = 0; i < WIN; i++) step(1'b1, ch, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_ch", out_ch, 0);
        check("rst_out_data", out_data, 0);
        check("rst_overrun", overrun, 0);
        exp_q.delete();
        exp_ovr = 1'b0;
        model_reset_chans();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b1;
        ena = 1'b1; in_valid = 1'b0; in_ch = '0; in_data = '0;
        clr = 1'b0; sel = 2'd0; out_ready = 1'b1;
`ifdef VEDM_AGG_THRESH_EN
        thresh = 8'h40;
`endif
        vec[0] = '{ch: 0, d0: 'h10, step: 0,    sel: 0, exp: 'h10};
        vec[1] = '{ch: 2, d0: 1,    step: 1,    sel: 1, exp: 'h01};
        vec[2] = '{ch: 2, d0: 1,    step: 1,    sel: 2, exp: 'h08};
        vec[3] = '{ch: 1, d0: 3,    step: 'h20, sel: 0, exp: 'h73};
        vec[4] = '{ch: 3, d0: 'hFF, step: 0,    sel: 0, exp: 'hFF};
        vec[5] = '{ch: 1, d0: 0,    step: 0,    sel: 3, exp: 'h08};
        vec[6] = '{ch: 0, d0: 'hF0, step: -16,  sel: 1, exp: 'h80};
        vec[7] = '{ch: 3, d0: 7,    step: 1,    sel: 0, exp: 'h0A};
        #1;
        do_reset();

        for (int k = 0; k < 8; k++) begin
            sel = 2'(vec[k].sel);
            pops_seen = 0;
            for (int i = 0; i < WIN; i++) step(1'b1, vec[k].ch, vec[k].d0 + i * vec[k].step);
            idle(2);
            check($sformatf("tbl%0d_pops", k), pops_seen, 1);
            check($sformatf("tbl%0d_data", k), last_pop_data, vec[k].exp);
        end

        // ch2 max window with ch1 samples interleaved, then finish ch1
        sel = 2'd2;
        for (int i = 0; i < WIN; i++) begin
            step(1'b1, 2, i + 1);
            if (i < 4) step(1'b1, 1, 'h50);
        end
        idle(2);
        check("ilv_ch2_max", last_pop_data, 'h08);
        sel = 2'd0;
        for (int i = 0; i < 4; i++) step(1'b1, 1, 'h50);
        idle(2);
        check("ilv_ch1_avg", last_pop_data, 'h50);

        // three frames into a stalled consumer
        out_ready = 1'b0;
        window(0, 'h11);
        window(0, 'h22);
        window(0, 'h33);
        idle(1);
        check("ovr_set", overrun, 1);
        out_ready = 1'b1;
        pops_seen = 0;
        idle(3);
        check("ovr_pops", pops_seen, 2);
        check("ovr_drained", out_valid, 0);

        // clear with a pending frame and a partial ch3 window
        out_ready = 1'b0;
        window(1, 'h44);
        for (int i = 0; i < 5; i++) step(1'b1, 3, 'h77);
        clr = 1'b1;
        step(1'b1, 3, 'h77);
        clr = 1'b0;
        check("clr_flush", out_valid, 0);
        check("clr_ovr", overrun, 0);
        out_ready = 1'b1;
        window(3, 'h20);
        idle(2);
        check("clr_avg", last_pop_data, 'h20);

        // push and pop on the same edge while full
        out_ready = 1'b0;
        pops_seen = 0;
        window(0, 'h01);
        window(0, 'h02);
        for (int i = 0; i < WIN - 1; i++) step(1'b1, 0, 'h03);
        out_ready = 1'b1;
        step(1'b1, 0, 'h03);
        idle(3);
        check("pp_no_ovr", overrun, 0);
        check("pp_pops", pops_seen, 3);
        check("pp_last", last_pop_data, 'h03);

        // out-of-range channel tags
        pops_seen = 0;
        for (int i = 0; i < 16; i++) step(1'b1, 4 + (i % 4), int'($urandom_range(0, 255)));
        check("oor_pops", pops_seen, 0);
        window(1, 'h40);
        idle(2);
        check("oor_ch1_avg", last_pop_data, 'h40);

        // enable low: no accept, no pop
        out_ready = 1'b0;
        window(2, 'h66);
        out_ready = 1'b1;
        ena = 1'b0;
        pops_seen = 0;
        for (int i = 0; i < 10; i++) step(1'b1, 2, 'hFF);
        check("ena_hold", out_valid, 1);
        check("ena_hold_data", out_data, 'h66);
        ena = 1'b1;
        idle(2);
        check("ena_pop", pops_seen, 1);
        window(2, 'h10);
        idle(2);
        check("ena_avg", last_pop_data, 'h10);

        // reset mid-window and mid-handshake
        out_ready = 1'b0;
        window(1, 'h55);
        for (int i = 0; i < 3; i++) step(1'b1, 2, 'h99);
        do_reset();
        out_ready = 1'b1;
        pops_seen = 0;
        window(2, 'h33);
        idle(2);
        check("rst_pops", pops_seen, 1);
        check("rst_avg", last_pop_data, 'h33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/energy_sample_aggregator.md
Name: energy_sample_aggregator

Overview:
- Parametrised successor to the single-channel voltage capture path. Samples N_CH multiplexed energy-source readings (solar, wind, battery, ...) arriving on an 8-bit input bus tagged by a channel index.
- Per channel it keeps a running-sum boxcar average over 2^LOG2_AVG samples, plus min and max trackers.
- Results stream out one channel per frame over a valid/ready handshake into the chip output register stage.

Parameters:
- DATA_W, 8, sample width in bits.
- N_CH, 4, channel count (2..8).
- LOG2_AVG, 3, log2 of the number of samples per average window (1..6).
- CH_W, 2, channel index width; equals clog2(N_CH).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- ena  in  1  global enable; when low, all state holds and no handshakes complete.
- in_valid  in  1  sample present on in_data this cycle.
- in_ch  in  CH_W  channel tag of the sample.
- in_data  in  DATA_W  unsigned sample.
- clr  in  1  synchronous clear of all accumulators and min/max.
- sel  in  2  output field select: 0=avg, 1=min, 2=max, 3=count.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_ch  out  CH_W  channel of the result.
- out_data  out  DATA_W  field chosen by sel, sampled at frame capture.
- overrun  out  1  sticky flag: a frame was dropped.

Behaviour:
- Reset values: out_valid=0, out_ch=0, out_data=0, overrun=0. All sums and counts are 0. min=all-ones, max=0.
- Sample accept: when ena && in_valid && in_ch<N_CH, the block updates on the next edge:
  - sum[ch] += in_data. Sum width is DATA_W+LOG2_AVG, so it cannot overflow.
  - cnt[ch] += 1.
  - min[ch] and max[ch] are updated.
- Out-of-range in_ch: the sample is ignored. There is no other effect.
- Window complete: when cnt[ch] reaches 2^LOG2_AVG-1 and a sample is accepted, a frame is formed for ch:
  - avg = (sum + in_data) >> LOG2_AVG, truncated.
  - The frame carries min, max, avg and count=2^LOG2_AVG, including the current sample.
  - sum[ch] and cnt[ch] clear. min[ch] and max[ch] reset to their reset values.
- Frame queue: a 2-entry skid FIFO. out_valid=1 whenever the FIFO is non-empty, with latency 1 cycle from the completing sample.
- Handshake: a frame is popped when out_valid && out_ready && ena. out_data and out_ch stay stable while out_valid && !out_ready.
- sel is registered into each frame when it is pushed. Changing sel later does not alter a pending frame.
- FIFO full and a new frame completes: the new frame is dropped and overrun is set. overrun clears only on rst_n or clr.
- Simultaneous push and pop when full: the pop happens first, the push succeeds, and overrun is not set.
- Simultaneous frames from two channels in one cycle are impossible, since there is one sample per cycle.
- clr:
  - Clears all accumulators, the FIFO and overrun.
  - out_valid drops the next cycle.
  - clr takes priority over a same-cycle sample.
- Reset mid-window: a partial window is discarded and no frame is emitted.
- State machine per FIFO slot: EMPTY -> ONE -> TWO. Transitions follow push/pop. The overrun check applies in TWO.

Optional Feature:
- Macro: VEDM_AGG_THRESH_EN.
- When defined:
  - Adds an input port thresh (DATA_W) and an output port alarm (N_CH).
  - alarm[ch] is registered high when a completed window's avg < thresh, and low when it is >= thresh.
  - alarm resets to 0 and clears on clr.
- When undefined: neither port exists, and behaviour is otherwise identical.

Decomposition:
- Package energy_agg_pkg holds:
  - sel encodings: SEL_AVG, SEL_MIN, SEL_MAX, SEL_CNT.
  - The frame struct typedef {ch, data}.
  - Reset constants for min/max.
- One sub-module, agg_frame_fifo: a 2-deep valid/ready skid FIFO with full/empty and drop detect.

Test Plan:
- Ch0 gets 8 samples of 0x10, sel=0, out_ready=1 -> one frame: out_ch=0, out_data=0x10, out_valid pulses 1 cycle after the 8th sample.
- Ch2 gets samples 1..8, with sel=1 then sel=2 in separate windows -> min=0x01, then max=0x08. Interleaved ch1 samples do not disturb ch2.
- Hold out_ready=0 while 3 windows complete -> first 2 frames retained with data stable, third dropped, overrun=1. Then out_ready=1 -> 2 pops, then out_valid=0.
- Assert clr after 5 of 8 samples on ch3, then send 8 more samples of 0x20 -> avg=0x20 with no contamination; clr also clears overrun.
- in_ch=5 with N_CH=4, 16 samples -> no frames and no state change. ena=0 with in_valid=1 -> samples are ignored and a pending frame is not popped.
- rst_n low for 1 cycle mid-window and mid-handshake -> all outputs 0 immediately (async); the next full window produces a correct avg.
